demux_1x4_sequencer: RTL
========================

# demux_1x4_sequencer

Upstream driver for the 1x4 demultiplexer. It accepts single-bit symbols over a valid/ready handshake and distributes them round-robin across the four demux channels. For each symbol it drives the demux data line `y` together with the select pair `S_1:S_0`, holds them for a programmable dwell time, then returns `y` to zero and advances to the next enabled channel. A one-cycle pulse marks the end of each full frame.

## Interface
- `DWELL`, default 4: cycles each accepted symbol is held on `y`; legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `din`  in  1  symbol to route.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  block can accept `din` this cycle.
- `ch_mask`  in  4  per-channel enable, bit i = channel i. Present only with `DEMUX_SEQ_MASK_EN`.
- `y`  out  1  demux data input, registered.
- `S_0`  out  1  demux select LSB, registered.
- `S_1`  out  1  demux select MSB, registered.
- `busy`  out  1  high while a symbol is being held.
- `frame_done`  out  1  one-cycle pulse after the last enabled channel of a frame is served.

## Operation
- Internal state:
  - FSM with states IDLE and DRIVE.
  - 2-bit channel pointer `ptr`.
  - 8-bit dwell counter `cnt`.
- `en[3:0]` = `ch_mask` when the macro is defined, otherwise 4'b1111.
- IDLE:
  - `din_ready` = `en[ptr]` (combinational).
  - If `en[ptr]` = 0 and `en` ≠ 0, `ptr` advances to the next enabled channel (ascending, wrap 3→0) and `din_ready` stays 0 that cycle.
  - If `en` = 0, `din_ready` = 0 and `ptr` holds.
- Accept occurs when `din_valid` && `din_ready`. On the accept edge:
  - `y` ← `din`
  - `{S_1,S_0}` ← `ptr`
  - `cnt` ← `DWELL`-1
  - `busy` ← 1
  - go to DRIVE.
- DRIVE:
  - `din_ready` = 0.
  - While `cnt` ≠ 0, `cnt` decrements each cycle.
  - On the edge where `cnt` = 0:
    - `y` ← 0 and `busy` ← 0.
    - `ptr` ← next enabled channel after `ptr` (ascending, wrap).
    - `frame_done` ← 1 if that next index ≤ the served index (wrap, or the only enabled channel); otherwise 0.
    - Go to IDLE.
- `S_1:S_0` change only on an accept edge. Between symbols they keep the last served channel, so the downstream demux never sees a select change while `y` = 1.
- `ch_mask` changes during DRIVE take effect at the pointer advance.
- `din` is sampled only at accept; changes during DRIVE are ignored.
- Reset, asynchronous and at any time including mid-DRIVE:
  - state IDLE, `ptr` = 0, `cnt` = 0.
  - `y` = 0, `S_0` = 0, `S_1` = 0, `busy` = 0, `frame_done` = 0.
  - A held symbol is dropped and not retried.
  - `din_ready` = `en[0]` after reset.

## Timing
- Accept at edge N:
  - `y` and `S` are valid from edge N for exactly `DWELL` cycles.
  - `y` returns to 0 at edge N+`DWELL`.
- `din_ready` is high again in the cycle after edge N+`DWELL`, if the next channel is enabled. Sustained throughput is one symbol per `DWELL`+1 cycles.
- `frame_done` is high for the single cycle following the `y`→0 edge of the frame's last symbol.
- `din_ready` is combinational from state, `ptr` and `en`. It has no combinational path from `din_valid`.
- With `DWELL` = 1, `cnt` is loaded with 0 and DRIVE lasts one cycle.

## Configuration
- `DEMUX_SEQ_MASK_EN` defined:
  - The `ch_mask` port exists.
  - Disabled channels are skipped.
  - An all-zero mask stalls the handshake.
- Not defined:
  - No `ch_mask` port.
  - All four channels are always served in order 0,1,2,3,0…
  - The skip logic is removed.

## Test plan
- Reset release, `DWELL`=4, feed 1,0,1,1 back-to-back with `din_valid` held high:
  - `{S_1,S_0}` = 0,1,2,3.
  - `y` high for 4 cycles on channels 0, 2 and 3.
  - Accepts 5 cycles apart.
  - `frame_done` pulses once, after channel 3.
- `din_valid` low for 10 cycles between symbols:
  - `y` = 0 and `S` holds the last channel for the whole gap.
  - `din_ready` = 1 throughout the gap.
- `rst` asserted 2 cycles into a DRIVE of channel 2:
  - `y`, `S_0`, `S_1`, `busy` go to 0 immediately.
  - The next accept goes to channel 0.
- Mask: `ch_mask`=4'b1010, feed 4 ones:
  - Channels served 1,3,1,3.
  - `frame_done` after each channel-3 symbol.
  - `S` never equals 0 or 2.
- Mask edge cases:
  - `ch_mask`=4'b0000 with `din_valid`=1 for 20 cycles: `din_ready` stays 0 and `y` stays 0.
  - `ch_mask`=4'b0100: every symbol goes to channel 2, with `frame_done` after each one.
- `DWELL`=1, continuous valid:
  - `y` is high 1 cycle per symbol.
  - Accepts occur every 2 cycles.
  - Select sequence 0,1,2,3,0.

Source files
------------

// File: rtl/demux_1x4_sequencer_if.sv
// Handshake and demux-side bundle for demux_1x4_sequencer.
// ch_mask exists only when DEMUX_SEQ_MASK_EN is defined.
interface demux_1x4_sequencer_if;
  logic       din;
  logic       din_valid;
  logic       din_ready;
`ifdef DEMUX_SEQ_MASK_EN
  logic [3:0] ch_mask;
`endif
  logic       y;
  logic       S_0;
  logic       S_1;
  logic       busy;
  logic       frame_done;

  // The sequencer itself sits on the slave side.
  modport slave (
    input  din,
    input  din_valid,
`ifdef DEMUX_SEQ_MASK_EN
    input  ch_mask,
`endif
    output din_ready,
    output y,
    output S_0,
    output S_1,
    output busy,
    output frame_done
  );

  modport master (
    output din,
    output din_valid,
`ifdef DEMUX_SEQ_MASK_EN
    output ch_mask,
`endif
    input  din_ready,
    input  y,
    input  S_0,
    input  S_1,
    input  busy,
    input  frame_done
  );
endinterface

// File: rtl/demux_1x4_sequencer.sv
// Round-robin driver for a 1x4 demux: holds each accepted symbol on y for DWELL cycles.
// Optional per-channel skipping is enabled by defining DEMUX_SEQ_MASK_EN.
module demux_1x4_sequencer #(
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  demux_1x4_sequencer_if.slave  bus
);

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] cnt;
  logic [1:0] sel;
  logic       y;
  logic       busy;
  logic       frame_done;
  logic [3:0] en;
  logic [1:0] nxt;

`ifdef DEMUX_SEQ_MASK_EN
  assign en = bus.ch_mask;

  // Nearest enabled channel strictly after cur, wrapping; falls back to cur
  // when cur is the only enabled channel or nothing is enabled.
  function automatic logic [1:0] next_enabled(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] r;
    r = cur;
    for (int i = 3; i >= 1; i--) begin
      if (m[2'(cur + 2'(i))]) r = 2'(cur + 2'(i));
    end
    return r;
  endfunction

  assign nxt = next_enabled(ptr, en);
`else
  assign en  = 4'b1111;
  assign nxt = 2'(ptr + 2'd1);
`endif

  assign bus.din_ready  = (state == IDLE) && en[ptr];
  assign bus.y          = y;
  assign bus.S_0        = sel[0];
  assign bus.S_1        = sel[1];
  assign bus.busy       = busy;
  assign bus.frame_done = frame_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      cnt        <= 8'd0;
      sel        <= 2'd0;
      y          <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (en[ptr]) begin
            if (bus.din_valid) begin
              y     <= bus.din;
              sel   <= ptr;
              cnt   <= 8'(DWELL - 1);
              busy  <= 1'b1;
              state <= DRIVE;
            end
          end else if (en != 4'b0000) begin
            ptr <= nxt;
          end
        end
        DRIVE: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            y     <= 1'b0;
            busy  <= 1'b0;
            ptr   <= nxt;
            // Wrapping (or staying put) means the frame's last channel was just served.
            frame_done <= (nxt <= ptr);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
